// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file write-port controller.
package regfile_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[rd] = (rd != '0);
        return v;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for port-B destinations: busy vector, pending count, issue gate and lookups.
module wb_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_iss_valid,
    input  logic [REG_ADDR_W-1:0] i_iss_rd,
    output logic                  o_iss_ready,
    input  logic                  i_clr_valid,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic [NUM_REGS-1:0]   o_busy
);

    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_LIM = PEND_W'(MAX_PEND);

    logic [NUM_REGS-1:0] r_busy;
    logic [PEND_W-1:0]   r_pend_cnt;
    logic                w_set;
    logic                w_clr;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Gate uses registered state only: a clear landing this cycle does not reopen the rd (WAW guard).
    always_comb begin
        o_iss_ready = 1'b1;
        if (i_iss_rd != '0) begin
            o_iss_ready = !r_busy[i_iss_rd] && (r_pend_cnt < PEND_LIM);
        end
    end

    assign w_set      = i_iss_valid && o_iss_ready && (i_iss_rd != '0);
    assign w_clr      = i_clr_valid && (i_clr_rd != '0);
    assign w_set_mask = w_set ? reg_onehot(i_iss_rd) : '0;
    assign w_clr_mask = w_clr ? reg_onehot(i_clr_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (w_set && !w_clr) begin
                r_pend_cnt <= r_pend_cnt + PEND_W'(1);
            end else if (w_clr && !w_set) begin
                r_pend_cnt <= r_pend_cnt - PEND_W'(1);
            end
        end
    end

    assign o_rs1_busy = r_busy[i_rs1];
    assign o_rs2_busy = r_busy[i_rs2];
    assign o_busy     = r_busy;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter (pipeline WB vs multi-cycle completion) with starvation bubble.
// Optional same-cycle forwarding outputs when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]       mc_data,
    output logic                  mc_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  stall_o,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                  rs1_fwd_hit,
    output logic                  rs2_fwd_hit,
    output logic [XLEN-1:0]       fwd_data,
`endif
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    wb_state_e           r_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_stall;
    logic                w_hs_b;
    logic                w_blocked;
    logic [NUM_REGS-1:0] w_busy;

    assign mc_ready  = !wb_valid;
    assign w_hs_b    = mc_valid && mc_ready;
    assign w_blocked = mc_valid && wb_valid;

    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (wb_valid) begin
            rf_we    = (wb_rd != '0);
            rf_rd    = wb_rd;
            rf_wdata = wb_data;
        end else if (w_hs_b) begin
            rf_we    = (mc_rd != '0);
            rf_rd    = mc_rd;
            rf_wdata = mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_blocked) begin
                        if (WAIT_LIM == WAIT_W'(1)) begin
                            r_state <= FORCE;
                            r_stall <= 1'b1;
                        end else begin
                            r_state    <= WAIT;
                            r_wait_cnt <= WAIT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (!mc_valid || w_hs_b) begin
                        r_state    <= IDLE;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt + WAIT_W'(1) == WAIT_LIM) begin
                        r_state    <= FORCE;
                        r_wait_cnt <= '0;
                        r_stall    <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                FORCE: begin
                    if (!mc_valid || w_hs_b) begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= '0;
                    r_stall    <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o = r_stall;

    wb_scoreboard #(
        .MAX_PEND (MAX_PEND)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .o_iss_ready (iss_ready),
        .i_clr_valid (w_hs_b),
        .i_clr_rd    (mc_rd),
        .i_rs1       (rs1),
        .i_rs2       (rs2),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_busy      (w_busy)
    );

`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_hit = rf_we && (rf_rd == rs1) && (rs1 != '0);
    assign rs2_fwd_hit = rf_we && (rf_rd == rs2) && (rs2 != '0);
    assign fwd_data    = rf_wdata;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(r_stall && wb_valid))
                else $error("regfile_wb_ctrl: wb_valid asserted during forced bubble");
            assert (!(wb_valid && w_busy[wb_rd]))
                else $error("regfile_wb_ctrl: pipeline writeback to busy rd %0d", wb_rd);
            assert (!(w_hs_b && (mc_rd != '0) && !w_busy[mc_rd]))
                else $error("regfile_wb_ctrl: completion to non-busy rd %0d", mc_rd);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (MAX_WAIT=4, MAX_PEND=4).
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall_o;
`ifdef REGFILE_WB_BYPASS_EN
    logic        rs1_fwd_hit;
    logic        rs2_fwd_hit;
    logic [31:0] fwd_data;
`endif
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(
        .MAX_WAIT (4),
        .MAX_PEND (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mc_valid  (mc_valid),
        .mc_rd     (mc_rd),
        .mc_data   (mc_data),
        .mc_ready  (mc_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .stall_o   (stall_o),
`ifdef REGFILE_WB_BYPASS_EN
        .rs1_fwd_hit (rs1_fwd_hit),
        .rs2_fwd_hit (rs2_fwd_hit),
        .fwd_data    (fwd_data),
`endif
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
        #1;
        check("issue_ready", {31'd0, iss_ready}, 32'd1);
        tick();
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        rs1 = '0; rs2 = '0;

        #12;
        check("rst_stall",    {31'd0, stall_o},   32'd0);
        check("rst_rf_we",    {31'd0, rf_we},     32'd0);
        check("rst_mc_ready", {31'd0, mc_ready},  32'd1);
        check("rst_iss_ready",{31'd0, iss_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Port B alone to rd 5
        issue(5'd5);
        rs1 = 5'd5;
        #1;
        check("b5_busy_set", {31'd0, rs1_busy}, 32'd1);
        mc_valid = 1'b1; mc_rd = 5'd5; mc_data = 32'hDEADBEEF;
        #1;
        check("b5_mc_ready", {31'd0, mc_ready}, 32'd1);
        check("b5_rf_we",    {31'd0, rf_we},    32'd1);
        check("b5_rf_rd",    {27'd0, rf_rd},    32'd5);
        check("b5_rf_wdata", rf_wdata,          32'hDEADBEEF);
        tick();
        mc_valid = 1'b0;
        #1;
        check("b5_busy_clr", {31'd0, rs1_busy}, 32'd0);
        check("b5_idle_we",  {31'd0, rf_we},    32'd0);
        check("b5_idle_wd",  rf_wdata,          32'd0);

        // A and B collide: A wins, B follows
        issue(5'd7);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h22;
        #1;
        check("ab_mc_ready", {31'd0, mc_ready}, 32'd0);
        check("ab_rf_we",    {31'd0, rf_we},    32'd1);
        check("ab_rf_rd",    {27'd0, rf_rd},    32'd3);
        check("ab_rf_wdata", rf_wdata,          32'h11);
        tick();
        wb_valid = 1'b0;
        rs2 = 5'd7;
        #1;
        check("ab_b_ready",  {31'd0, mc_ready}, 32'd1);
        check("ab_b_rf_rd",  {27'd0, rf_rd},    32'd7);
        check("ab_b_wdata",  rf_wdata,          32'h22);
        check("ab_stall",    {31'd0, stall_o},  32'd0);
        tick();
        mc_valid = 1'b0;
        #1;
        check("ab_rd7_clr",  {31'd0, rs2_busy}, 32'd0);

        // Starvation: four blocked cycles, bubble in the fifth
        issue(5'd6);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hA;
        mc_valid = 1'b1; mc_rd = 5'd6; mc_data = 32'h66;
        tick();
        check("st_c2", {31'd0, stall_o}, 32'd0);
        tick();
        check("st_c3", {31'd0, stall_o}, 32'd0);
        tick();
        check("st_c4", {31'd0, stall_o}, 32'd0);
        tick();
        check("st_c5", {31'd0, stall_o}, 32'd1);
        wb_valid = 1'b0;
        #1;
        check("st_b_rf_rd", {27'd0, rf_rd},    32'd6);
        check("st_b_wdata", rf_wdata,          32'h66);
        check("st_b_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;
        check("st_c6", {31'd0, stall_o}, 32'd0);

        // WAW guard on rd 9
        issue(5'd9);
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        check("waw_busy", {31'd0, iss_ready}, 32'd0);
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
        #1;
        check("waw_clr_cycle", {31'd0, iss_ready}, 32'd0);
        tick();
        mc_valid = 1'b0;
        #1;
        check("waw_after", {31'd0, iss_ready}, 32'd1);
        iss_valid = 1'b0; iss_rd = 5'd0;

        // Pending limit, then asynchronous reset mid-stream
        issue(5'd10);
        issue(5'd11);
        issue(5'd12);
        issue(5'd13);
        iss_rd = 5'd14;
        #1;
        check("pend_full", {31'd0, iss_ready}, 32'd0);
        iss_rd = 5'd0;
        #1;
        check("pend_x0", {31'd0, iss_ready}, 32'd1);
        rs1 = 5'd13;
        #1;
        check("pend_busy13", {31'd0, rs1_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {31'd0, rs1_busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall_o},  32'd0);
        iss_rd = 5'd14;
        #1;
        check("mid_rst_ready", {31'd0, iss_ready}, 32'd1);
        iss_rd = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(5'd14);

        // Writes to x0 are granted but not performed
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5;
        #1;
        check("x0_a_we",    {31'd0, rf_we},    32'd0);
        check("x0_a_ready", {31'd0, mc_ready}, 32'd0);
        tick();
        wb_valid = 1'b0;
        mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h7;
        #1;
        check("x0_b_we",    {31'd0, rf_we},    32'd0);
        check("x0_b_ready", {31'd0, mc_ready}, 32'd1);
        tick();
        mc_valid = 1'b0;

`ifdef REGFILE_WB_BYPASS_EN
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444;
        rs1 = 5'd4;
        #1;
        check("fwd_hit",  {31'd0, rs1_fwd_hit}, 32'd1);
        check("fwd_data", fwd_data,             32'h4444);
        wb_rd = 5'd0; rs1 = 5'd0;
        #1;
        check("fwd_x0_hit", {31'd0, rs1_fwd_hit}, 32'd0);
        check("fwd_x0_we",  {31'd0, rf_we},       32'd0);
        tick();
        wb_valid = 1'b0;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the 32×32 integer register file: the file's single write port is shared between the in-order pipeline writeback (port A) and a multi-cycle completion unit (port B: loads, mul/div). A 32-bit busy scoreboard tracks destinations issued to port B, so the hazard unit can stall dependent instructions. A starvation counter forces a one-cycle pipeline bubble when port B has waited too long. The block drives the register file's RegWrite, rd and WriteData inputs directly.

## Interface
- MAX_WAIT, 4: consecutive blocked port-B cycles before a forced bubble; must be ≥1.
- MAX_PEND, 4: maximum outstanding port-B destinations; must be between 1 and 31.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wb_valid, wb_rd, wb_data  in  1/5/32  pipeline writeback request (port A); never back-pressured.
- mc_valid, mc_rd, mc_data  in  1/5/32  multi-cycle completion request (port B).
- mc_ready  out  1  port-B grant.
- iss_valid, iss_rd  in  1/5  issue of a port-B op; marks iss_rd busy.
- iss_ready  out  1  issue may proceed.
- rs1, rs2  in  5/5  hazard lookup addresses.
- rs1_busy, rs2_busy  out  1/1  scoreboard lookup result.
- stall_o  out  1  registered; pipeline must bubble WB this cycle.
- rf_we, rf_rd, rf_wdata  out  1/5/32  to register file RegWrite/rd/WriteData.

## Operation
- Port A has priority. mc_ready = !wb_valid, purely combinational.
- Port B handshake: mc_valid && mc_ready. Once asserted, mc_valid, mc_rd and mc_data hold stable until the handshake.
- Write mux:
  - wb_valid → A.
  - Otherwise, B handshake → B.
  - Otherwise rf_we=0, rf_rd=0, rf_wdata=0.
  - rf_we is suppressed when the selected rd==0; the grant still completes.
- FSM states:
  - IDLE: no blocked port-B request.
  - WAIT: port B blocked; wait_cnt increments each blocked cycle.
  - FORCE: stall_o=1.
- Transitions:
  - IDLE→WAIT on mc_valid && wb_valid.
  - WAIT→IDLE on handshake or mc_valid low; wait_cnt clears.
  - WAIT→FORCE when the blocked cycle count reaches MAX_WAIT.
  - FORCE→IDLE on handshake, or on mc_valid dropping (protocol error).
- While stall_o=1, wb_valid must be 0 (assertion). B therefore wins that cycle, and stall_o falls on the next edge.
- Scoreboard:
  - busy[iss_rd] is set on iss_valid && iss_ready && iss_rd!=0; pend_cnt increments.
  - busy[mc_rd] is cleared on port-B handshake with mc_rd!=0; pend_cnt decrements.
  - A simultaneous set and clear leaves pend_cnt unchanged.
- iss_ready:
  - iss_rd==0: iss_ready=1; nothing is recorded.
  - Otherwise: iss_ready = !busy[iss_rd] && pend_cnt<MAX_PEND, using registered state only. A same-cycle clear of iss_rd does not raise iss_ready (WAW guard).
- rsN_busy = busy[rsN] combinationally; x0 is never busy.
- Assertions:
  - wb_valid with wb_rd busy is illegal.
  - Port-B handshake to a non-busy rd!=0 is illegal.

## Timing
- Write path has zero latency: the request cycle's rf_* values are written at that cycle's rising edge. Register-file read-back is visible the following cycle.
- mc_ready and rsN_busy are combinational. stall_o, busy and pend_cnt are registered.
- Forced bubble: stall_o rises on the edge after the MAX_WAIT-th consecutive blocked cycle. It lasts exactly one cycle when the protocol is obeyed.
- Reset (async assert, sync deassert upstream):
  - FSM=IDLE, wait_cnt=0, busy=0, pend_cnt=0, stall_o=0.
  - rf_we=0 and mc_ready=1 once inputs are idle.
- Reset mid-operation discards all pending busy bits. The issuing side must flush.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - Adds outputs rs1_fwd_hit, rs2_fwd_hit and fwd_data (= rf_wdata).
  - rsN_fwd_hit = rf_we && rf_rd==rsN && rsN!=0. This lets same-cycle readers bypass the register file's pre-edge value.
- Undefined: these ports and their logic are absent. Readers see the new value one cycle after the write.

## Structure
- Package regfile_ctrl_pkg: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and an FSM enum {IDLE, WAIT, FORCE}.
- Sub-module wb_scoreboard: busy vector, pend_cnt, iss_ready and rsN_busy lookup.
- Top level: write mux, FSM, wait_cnt, and bypass logic.

## Test plan
- Port B alone, mc_rd=5, data 0xDEADBEEF → handshake the same cycle; rf_we=1, rf_rd=5; busy[5] clears next cycle.
- Port A (rd=3, 0x11) and port B (rd=7, 0x22) simultaneous → A written, mc_ready=0. With A idle the next cycle, B writes rd=7.
- wb_valid held high, mc_valid waiting, MAX_WAIT=4 → stall_o=1 on the 5th cycle. B writes that cycle; stall_o=0 on the next cycle.
- Issue rd=9, then re-issue rd=9 → iss_ready=0. It stays 0 in the clear cycle and returns to 1 the cycle after.
- Issue 4 distinct rds with MAX_PEND=4 → iss_ready=0 for a 5th. Assert rst_n low mid-stream → busy=0, stall_o=0, iss_ready=1.
- With REGFILE_WB_BYPASS_EN: A writes rd=4 with rs1=4 → rs1_fwd_hit=1, fwd_data equals wb_data. With rd=0 → no write and no hit.
